paillier_multi_exp: RTL and testbench
=====================================

# paillier_multi_exp

- Parametrised homomorphic linear-combination engine for the encrypted controller datapath.
- Computes the product of c_i^k_i mod M over NUM_CH Paillier ciphertexts, i.e. the encryption of sum k_i·x_i. Uses interleaved (Shamir) square-and-multiply in the Montgomery domain.
- Generalises the fixed two-state PD gain stage: channel count, key width and gain width are all parameters, and the block exposes busy/done status.

## Interface
- NUM_CH, 4, number of ciphertext/gain channels (≥1)
- KEY_W, 512, ciphertext and modulus width in bits
- GAIN_W, 8, unsigned gain (exponent) width in bits
- clk  in  1  single clock, rising edge
- rst  in  1  reset, synchronous, active-high
- start  in  1  one-cycle request; accepted only when busy=0
- modulus  in  KEY_W  odd modulus (N²); sampled on accepted start
- one_mont  in  KEY_W  R mod modulus, where R = 2^KEY_W; sampled on accepted start
- cipher  in  NUM_CH*KEY_W  channel i at bits [i*KEY_W +: KEY_W], Montgomery form; sampled on accepted start
- gain  in  NUM_CH*GAIN_W  channel i at bits [i*GAIN_W +: GAIN_W]; sampled on accepted start
- busy  out  1  high from the cycle after an accepted start until done
- done  out  1  one-cycle pulse; result is valid from this cycle onwards
- result  out  KEY_W  Montgomery-form product; holds its value until the next done

## Operation
- Reset values: busy=0, done=0, result=0, FSM in IDLE.
- FSM states:
  - IDLE: on start, register all inputs, set acc=one_mont, bit index b=GAIN_W-1, then go to SQR.
  - SQR: issue acc·acc, wait for the multiplier, then go to CH with ch=0.
  - CH: if gain[ch][b]=1, issue acc·cipher[ch] and wait; otherwise do nothing for this channel. Increment ch. After the last channel go to NEXT.
  - NEXT: if b=0 go to FIN; otherwise decrement b and go to SQR.
  - FIN: result←acc, done=1 for one cycle, return to IDLE.
- Multiplier: radix-2 bit-serial Montgomery. Each step is t←(t + a_j·b); if t is odd, t←t+modulus; then t←t>>1. This runs for KEY_W steps, followed by one conditional subtract when t≥modulus.
- Width rule: the internal accumulator t is KEY_W+2 bits wide; acc and result are KEY_W bits.
- Operands must be < modulus and modulus must be odd. Any other input gives an undefined result but must not hang the FSM.
- A start while busy=1 is ignored: no effect, no queueing.
- rst mid-operation aborts immediately. Outputs take their reset values and no done is issued.
- All gains zero: the result equals one_mont.
- Skipped channels (gain bit 0) cost 0 cycles.

## Timing
- Each issued multiply costs exactly KEY_W+3 cycles, from the FSM issue cycle to the cycle it consumes the product.
- Let M = number of issued multiplies. done asserts at cycle t_start + 2 + M·(KEY_W+3).
- Without the skip feature, M = GAIN_W + total popcount of all gains.
- Back-to-back: a new start is accepted in the cycle after done.

## Configuration
- PAILLIER_MEXP_SKIP_LEAD_EN defined:
  - An internal flag "seen" is cleared on start and set by the first issued channel multiply.
  - SQR is bypassed (0 cycles, no multiply issued) while seen=0.
  - M = popcount + (number of SQR steps after the first set bit).
- PAILLIER_MEXP_SKIP_LEAD_EN undefined: every one of the GAIN_W SQR steps is issued.
- The result value is identical in both builds; only the latency differs.

## Structure
- paillier_pkg holds:
  - the FSM state enum (IDLE, SQR, CH, NEXT, FIN);
  - the localparam MUL_CYC = KEY_W+3;
  - a function mexp_latency(M, KEY_W) for the bench.
- Sub-module mont_mul_r2 (ports clk, rst, start, a, b, modulus, done, p) holds the bit-serial multiplier. The top contains only the FSM and the operand mux.

## Test plan
All scenarios use KEY_W=8, GAIN_W=4, modulus=0xF1, one_mont=0x0F.
- Reset value: assert rst during an operation → busy=0, done=0 and result=0 the next cycle; no late done follows.
- All-zero gains: NUM_CH=2, all gains 0 → result=0x0F.
  - Skip undefined: done at t+2+4·11 = t+46.
  - Skip defined: done at t+2.
- Single channel: NUM_CH=1, cipher=0x1E (2), gain=3 → result=0x78 (8).
  - Skip undefined: done at t+68.
  - Skip defined: done at t+35.
- Two channels: NUM_CH=2, cipher={0x2D, 0x1E} (3, 2), gains {2, 1} → result=0x1D (18).
- Handshake: pulse start again while busy with different inputs → ignored, first result unchanged. A start in the cycle after done is accepted.
- Input hold: change cipher and gain one cycle after an accepted start → result matches the values sampled at start.

Source files
------------

// File: rtl/paillier_pkg.sv
// rtl/paillier_pkg.sv - shared FSM encoding and timing helpers for paillier_multi_exp
package paillier_pkg;

    typedef enum logic [2:0] {IDLE, SQR, CH, NEXT, FIN} mexp_state_t;

    localparam int DEF_KEY_W = 512;
    localparam int MUL_CYC   = DEF_KEY_W + 3;

    // Cycles from accepted start to done for m issued multiplies.
    function automatic int mexp_latency(input int m, input int key_w);
        return 2 + m * (key_w + 3);
    endfunction

endpackage

// File: rtl/mont_mul_r2.sv
// rtl/mont_mul_r2.sv - radix-2 bit-serial Montgomery multiplier, p = a*b*2^-KEY_W mod modulus
module mont_mul_r2 #(
    parameter int KEY_W = 512
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [KEY_W-1:0] a,
    input  logic [KEY_W-1:0] b,
    input  logic [KEY_W-1:0] modulus,
    output logic             done,
    output logic [KEY_W-1:0] p
);

    localparam int TW = KEY_W + 2;
    localparam int CW = $clog2(KEY_W + 1);

    logic [KEY_W-1:0] ra, rb, rm;
    logic [TW-1:0]    t, s1, s2;
    logic [CW-1:0]    cnt;
    logic             run, sub;

    always_comb begin
        s1 = t + (ra[0] ? {2'b00, rb} : '0);
        s2 = s1[0] ? s1 + {2'b00, rm} : s1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ra   <= '0;
            rb   <= '0;
            rm   <= '0;
            t    <= '0;
            cnt  <= '0;
            run  <= 1'b0;
            sub  <= 1'b0;
            done <= 1'b0;
            p    <= '0;
        end else begin
            done <= 1'b0;
            if (start && !run && !sub) begin
                ra  <= a;
                rb  <= b;
                rm  <= modulus;
                t   <= '0;
                cnt <= '0;
                run <= 1'b1;
            end else if (run) begin
                // a is consumed LSB first, one bit per cycle
                t   <= s2 >> 1;
                ra  <= ra >> 1;
                cnt <= cnt + 1'b1;
                if (cnt == CW'(KEY_W - 1)) begin
                    run <= 1'b0;
                    sub <= 1'b1;
                end
            end else if (sub) begin
                p    <= (t >= {2'b00, rm}) ? KEY_W'(t - {2'b00, rm}) : t[KEY_W-1:0];
                done <= 1'b1;
                sub  <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/paillier_multi_exp.sv
// rtl/paillier_multi_exp.sv - interleaved multi-exponentiation FSM over NUM_CH Montgomery ciphertexts
// PAILLIER_MEXP_SKIP_LEAD_EN: bypass squarings before the first issued channel multiply.
module paillier_multi_exp
    import paillier_pkg::*;
#(
    parameter int NUM_CH = 4,
    parameter int KEY_W  = 512,
    parameter int GAIN_W = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    input  logic [KEY_W-1:0]         modulus,
    input  logic [KEY_W-1:0]         one_mont,
    input  logic [NUM_CH*KEY_W-1:0]  cipher,
    input  logic [NUM_CH*GAIN_W-1:0] gain,
    output logic                     busy,
    output logic                     done,
    output logic [KEY_W-1:0]         result
);

`ifdef PAILLIER_MEXP_SKIP_LEAD_EN
    localparam bit SKIP_LEAD = 1'b1;
`else
    localparam bit SKIP_LEAD = 1'b0;
`endif

    // Schedule slots: per bit, slot 0 is the squaring, slots 1..NUM_CH the channels.
    localparam int TOT   = GAIN_W * (NUM_CH + 1);
    localparam int CUR_W = $clog2(TOT + 1);
    localparam int CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    mexp_state_t             state;
    logic [CUR_W-1:0]        cur, sel;
    logic [CH_W-1:0]         sel_ch;
    logic                    found, sel_sqr, seen;
    logic [KEY_W-1:0]        acc, acc_now, mod_r, mul_b, mul_p;
    logic [NUM_CH*KEY_W-1:0] cipher_r;
    logic [NUM_CH*GAIN_W-1:0] gain_r;
    logic                    mul_start, mul_done, dispatch;
    int                      slot, ch_i, bit_i;

    // Find the next slot from cur that needs a multiply; skipped slots cost no cycles.
    always_comb begin
        found   = 1'b0;
        sel     = '0;
        sel_sqr = 1'b0;
        sel_ch  = '0;
        slot    = 0;
        ch_i    = 0;
        bit_i   = 0;
        for (int i = 0; i < TOT; i++) begin
            slot  = i % (NUM_CH + 1);
            ch_i  = (slot == 0) ? 0 : slot - 1;
            bit_i = GAIN_W - 1 - i / (NUM_CH + 1);
            if (!found && i >= int'(cur)) begin
                if (slot == 0) begin
                    if (!SKIP_LEAD || seen) begin
                        found   = 1'b1;
                        sel     = CUR_W'(i);
                        sel_sqr = 1'b1;
                    end
                end else if (gain_r[ch_i*GAIN_W + bit_i]) begin
                    found  = 1'b1;
                    sel    = CUR_W'(i);
                    sel_ch = CH_W'(ch_i);
                end
            end
        end
    end

    assign dispatch = (state == NEXT) || (((state == SQR) || (state == CH)) && mul_done);
    assign acc_now  = (state == NEXT) ? acc : mul_p;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            cur       <= '0;
            seen      <= 1'b0;
            acc       <= '0;
            mod_r     <= '0;
            cipher_r  <= '0;
            gain_r    <= '0;
            mul_b     <= '0;
            mul_start <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            result    <= '0;
        end else begin
            mul_start <= 1'b0;
            done      <= 1'b0;
            case (state)
                IDLE: if (start) begin
                    mod_r    <= modulus;
                    cipher_r <= cipher;
                    gain_r   <= gain;
                    acc      <= one_mont;
                    cur      <= '0;
                    seen     <= 1'b0;
                    busy     <= 1'b1;
                    state    <= NEXT;
                end
                NEXT, SQR, CH: if (dispatch) begin
                    acc <= acc_now;
                    if (found) begin
                        mul_start <= 1'b1;
                        mul_b     <= sel_sqr ? acc_now : cipher_r[sel_ch*KEY_W +: KEY_W];
                        cur       <= sel + 1'b1;
                        state     <= sel_sqr ? SQR : CH;
                        if (!sel_sqr)
                            seen <= 1'b1;
                    end else begin
                        result <= acc_now;
                        done   <= 1'b1;
                        state  <= FIN;
                    end
                end
                FIN: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    mont_mul_r2 #(.KEY_W(KEY_W)) u_mul (
        .clk     (clk),
        .rst     (rst),
        .start   (mul_start),
        .a       (acc),
        .b       (mul_b),
        .modulus (mod_r),
        .done    (mul_done),
        .p       (mul_p)
    );

endmodule

// File: tb/tb_paillier_multi_exp.sv
// tb/tb_paillier_multi_exp.sv - scoreboard bench for paillier_multi_exp with a modular-arithmetic model
module tb_paillier_multi_exp;

    localparam int K = 8;
    localparam int G = 4;
    localparam int N = 2;
    localparam int MODV = 241;
    localparam int ONEV = 15;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         start = 1'b0;
    logic [K-1:0] modulus = K'(MODV);
    logic [K-1:0] one_mont = K'(ONEV);
    logic [N*K-1:0] cipher = '0;
    logic [N*G-1:0] gain = '0;
    logic         busy, done;
    logic [K-1:0] result;

    typedef struct {
        int res;
        int cyc;
    } exp_t;

    exp_t q[$];
    int   cyc = 0;
    int   n_vec = 0;
    int   n_bad = 0;
    int   rinv = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    paillier_multi_exp #(.NUM_CH(N), .KEY_W(K), .GAIN_W(G)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .modulus  (modulus),
        .one_mont (one_mont),
        .cipher   (cipher),
        .gain     (gain),
        .busy     (busy),
        .done     (done),
        .result   (result)
    );

    task automatic check(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Leave the Montgomery domain, exponentiate plainly, re-enter with R = 256.
    function automatic int ref_res(input int c0, input int c1, input int g0, input int g1);
        int x0, x1, r;
        x0 = (c0 * rinv) % MODV;
        x1 = (c1 * rinv) % MODV;
        r  = 1;
        for (int j = 0; j < g0; j++) r = (r * x0) % MODV;
        for (int j = 0; j < g1; j++) r = (r * x1) % MODV;
        return (r * 256) % MODV;
    endfunction

    function automatic int ref_lat(input int g0, input int g1);
        int pc, top, m;
        pc  = 0;
        top = -1;
        for (int b = 0; b < G; b++) begin
            if (((g0 >> b) & 1) == 1) pc++;
            if (((g1 >> b) & 1) == 1) pc++;
            if ((((g0 | g1) >> b) & 1) == 1) top = b;
        end
`ifdef PAILLIER_MEXP_SKIP_LEAD_EN
        m = pc + ((top > 0) ? top : 0);
`else
        m = G + pc;
`endif
        return 2 + m * (K + 3);
    endfunction

    task automatic issue(input int c0, input int c1, input int g0, input int g1, input bit expect_done);
        exp_t e;
        @(negedge clk);
        cipher = {c1[K-1:0], c0[K-1:0]};
        gain   = {g1[G-1:0], g0[G-1:0]};
        start  = 1'b1;
        if (expect_done) begin
            e.res = ref_res(c0, c1, g0, g1);
            e.cyc = cyc + ref_lat(g0, g1);
            q.push_back(e);
        end
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_empty();
        for (int i = 0; i < 3000 && q.size() != 0; i++) @(negedge clk);
        if (q.size() != 0) begin
            check("done_timeout", 0, 1);
            q.delete();
        end
        @(negedge clk);
    endtask

    task automatic wait_done();
        int i;
        i = 0;
        while (!done && i < 3000) begin
            @(negedge clk);
            i++;
        end
        if (!done) check("done_wait_timeout", 0, 1);
    endtask

    always @(negedge clk) begin
        if (!rst && done) begin
            if (q.size() == 0) begin
                check("unexpected_done", 1, 0);
            end else begin
                exp_t e;
                e = q.pop_front();
                check("result", int'(result), e.res);
                check("done_cycle", cyc, e.cyc);
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        for (int j = 1; j < MODV; j++)
            if ((256 * j) % MODV == 1) rinv = j;

        repeat (3) @(negedge clk);
        check("reset_busy", int'(busy), 0);
        check("reset_done", int'(done), 0);
        check("reset_result", int'(result), 0);
        rst = 1'b0;
        @(negedge clk);

        issue(8'h5A, 8'h33, 0, 0, 1'b1);
        wait_empty();
        issue(8'h1E, 8'h77, 3, 0, 1'b1);
        wait_empty();
        issue(8'h1E, 8'h2D, 1, 2, 1'b1);
        wait_empty();
        issue(8'h2D, 8'h1E, 4'hF, 4'h9, 1'b1);
        wait_empty();

        // Starts while busy are ignored; a start right after done is taken.
        issue(8'h1E, 8'h2D, 2, 1, 1'b1);
        check("busy_high", int'(busy), 1);
        @(negedge clk);
        cipher = {8'h10, 8'h20};
        gain   = 8'hFF;
        start  = 1'b1;
        @(negedge clk);
        start  = 1'b0;
        repeat (5) @(negedge clk);
        start  = 1'b1;
        @(negedge clk);
        start  = 1'b0;
        wait_done();
        issue(8'h3C, 8'h05, 5, 6, 1'b1);
        wait_empty();

        // Inputs changed one cycle after acceptance must not leak in.
        issue(8'h44, 8'h91, 4'hA, 4'h3, 1'b1);
        cipher = {8'h01, 8'h02};
        gain   = 8'h00;
        wait_empty();

        for (int n = 0; n < 16; n++) begin
            issue(int'($urandom_range(MODV - 1, 0)), int'($urandom_range(MODV - 1, 0)),
                  int'($urandom_range(15, 0)), int'($urandom_range(15, 0)), 1'b1);
            wait_empty();
        end

        // Abort mid-operation: outputs clear and no done follows.
        issue(8'h1E, 8'h2D, 4'hF, 4'hF, 1'b0);
        repeat (10) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("abort_busy", int'(busy), 0);
        check("abort_done", int'(done), 0);
        check("abort_result", int'(result), 0);
        rst = 1'b0;
        repeat (200) @(negedge clk);

        issue(8'h1E, 8'h00, 3, 0, 1'b1);
        wait_empty();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
